// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int RegWidth = 32;

  // Encoding of addi x0,x0,0, placed in the instruction slot of a bubble.
  localparam logic [RegWidth-1:0] NopWord        = 32'h0000_0013;
  localparam logic [RegWidth-1:0] ResetPcDefault = 32'h0000_0000;
  localparam logic [RegWidth-1:0] PcStep         = 32'd4;

  typedef struct packed {
    logic [RegWidth-1:0] pc;
    logic [RegWidth-1:0] pc4;
    logic [RegWidth-1:0] instruction;
    logic                valid;
  } if_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  function automatic if_id_t make_bubble(input logic [RegWidth-1:0] nop);
    if_id_t b;
    b.pc          = '0;
    b.pc4         = '0;
    b.instruction = nop;
    b.valid       = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, talks to instruction memory over a
// req/ack handshake and registers the IF/ID payload consumed by decode.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | first cycle after reset release, no request issued
//  FETCH | request at addr_q (== pc_q) outstanding
//  HOLD  | word fetched while ID stalled, parked in the one-entry buffer
//  DROP  | redirect arrived before ack; waiting to retire the stale request
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [RegWidth-1:0] ResetPc  = ResetPcDefault,
  parameter logic [RegWidth-1:0] NopInstr = NopWord
) (
  input  logic                iClk,
  input  logic                nRst,
  input  logic                iStall,
  input  logic                iFlush,
  input  logic                iBrTrue,
  input  logic [RegWidth-1:0] iBrPc,
  output logic                oImemReq,
  output logic [RegWidth-1:0] oImemAddr,
  input  logic                iImemAck,
  input  logic [RegWidth-1:0] iImemData,
  output if_id_t              oID
);

  fetch_state_t        state_q, state_d;
  logic [RegWidth-1:0] pc_q, pc_d;
  logic [RegWidth-1:0] addr_q, addr_d;
  if_id_t              buf_q, buf_d;
  if_id_t              id_q, id_d;

  if_id_t              bubble;
  if_id_t              fetched;
  if_id_t              item;
  logic                deliver;
  logic                addr_keep;
  logic [RegWidth-1:0] br_target;

  assign bubble    = make_bubble(NopInstr);
  assign br_target = {iBrPc[RegWidth-1:2], 2'b00};

  always_comb begin
    fetched.pc          = pc_q;
    fetched.pc4         = pc_q + PcStep;
    fetched.instruction = iImemData;
    fetched.valid       = 1'b1;
  end

  // Next-state logic: FSM transitions, PC update, buffer and IF/ID payload.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    item      = bubble;
    deliver   = 1'b0;
    addr_keep = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (iImemAck) begin
          if (iBrTrue) begin
            // Wrong-path word: discard it and restart at the target.
            pc_d = br_target;
          end else begin
            pc_d = pc_q + PcStep;
            if (iStall) begin
              buf_d   = fetched;
              state_d = HOLD;
            end else begin
              deliver = 1'b1;
              item    = fetched;
            end
          end
        end else if (iBrTrue) begin
          // The request must stay stable until acked, so the old address
          // is kept on the bus while the new target waits in pc_q.
          pc_d      = br_target;
          addr_keep = 1'b1;
          state_d   = DROP;
        end
      end

      HOLD: begin
        if (iBrTrue) begin
          buf_d   = bubble;
          pc_d    = br_target;
          state_d = FETCH;
        end else if (iFlush) begin
          buf_d   = bubble;
          state_d = FETCH;
        end else if (!iStall) begin
          deliver    = 1'b1;
          item       = buf_q;
          item.valid = 1'b1;
          buf_d      = bubble;
          state_d    = FETCH;
        end
      end

      DROP: begin
        if (iBrTrue) begin
          pc_d = br_target;
        end
        if (iImemAck) begin
          state_d = FETCH;
        end else begin
          addr_keep = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    addr_d = addr_keep ? addr_q : pc_d;

    if (iFlush) begin
      id_d = bubble;
    end else if (iStall) begin
      id_d = id_q;
    end else if (deliver) begin
      id_d = item;
    end else begin
      id_d = bubble;
    end
  end

  // State registers; reset abandons any outstanding request immediately.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      pc_q    <= ResetPc;
      addr_q  <= ResetPc;
      buf_q   <= make_bubble(NopInstr);
      id_q    <= make_bubble(NopInstr);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      id_q    <= id_d;
    end
  end

  assign oImemReq  = (state_q == FETCH) || (state_q == DROP);
  assign oImemAddr = addr_q;
  assign oID       = id_q;

  // Redirect targets are word addresses; nonzero low bits indicate an ID bug.
  a_br_aligned: assert property (@(posedge iClk) disable iff (!nRst)
                                 iBrTrue |-> (iBrPc[1:0] == 2'b00));

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        iClk = 1'b0;
  logic        nRst = 1'b0;
  logic        iStall = 1'b0;
  logic        iFlush = 1'b0;
  logic        iBrTrue = 1'b0;
  logic [31:0] iBrPc = '0;
  logic        oImemReq;
  logic [31:0] oImemAddr;
  logic        iImemAck = 1'b0;
  logic [31:0] iImemData = '0;
  if_id_t      oID;

  int checks = 0;
  int failures = 0;

  instr_fetch #(.ResetPc(32'h0000_0000), .NopInstr(NOP)) dut (
    .iClk      (iClk),
    .nRst      (nRst),
    .iStall    (iStall),
    .iFlush    (iFlush),
    .iBrTrue   (iBrTrue),
    .iBrPc     (iBrPc),
    .oImemReq  (oImemReq),
    .oImemAddr (oImemAddr),
    .iImemAck  (iImemAck),
    .iImemData (iImemData),
    .oID       (oID)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  function automatic if_id_t bub();
    if_id_t b;
    b.pc = '0; b.pc4 = '0; b.instruction = NOP; b.valid = 1'b0;
    return b;
  endfunction

  // Reference model: a started flag, a "stale request outstanding" flag and
  // a single parked instruction describe the whole fetch unit.
  bit          m_started, m_stale, m_held_v;
  logic [31:0] m_pc, m_addr;
  if_id_t      m_held, m_id;

  task automatic model_reset();
    m_started = 0; m_stale = 0; m_held_v = 0;
    m_pc = 32'h0; m_addr = 32'h0;
    m_held = bub(); m_id = bub();
  endtask

  function automatic bit m_req();
    return m_started && !m_held_v;
  endfunction

  task automatic model_step(input bit stall, input bit flush, input bit br,
                            input logic [31:0] brpc, input bit ack, input logic [31:0] data);
    if_id_t      item;
    bit          deliver;
    logic [31:0] tgt;
    item = bub();
    deliver = 0;
    tgt = brpc & 32'hFFFF_FFFC;
    if (!m_started) begin
      m_started = 1;
    end else if (m_held_v) begin
      if (br) begin m_held_v = 0; m_pc = tgt; end
      else if (flush) m_held_v = 0;
      else if (!stall) begin deliver = 1; item = m_held; m_held_v = 0; end
    end else if (m_stale) begin
      if (br) m_pc = tgt;
      if (ack) m_stale = 0;
    end else begin
      if (br) begin
        m_pc = tgt;
        if (!ack) m_stale = 1;
      end else if (ack) begin
        item.pc = m_pc; item.pc4 = m_pc + 32'd4; item.instruction = data; item.valid = 1'b1;
        m_pc = m_pc + 32'd4;
        if (stall) begin m_held = item; m_held_v = 1; end
        else deliver = 1;
      end
    end
    if (!m_stale) m_addr = m_pc;
    if (flush) m_id = bub();
    else if (!stall) m_id = deliver ? item : bub();
  endtask

  task automatic check_outputs();
    check("req", {31'b0, oImemReq}, {31'b0, m_req()});
    if (m_req()) check("addr", oImemAddr, m_addr);
    check("id_pc", oID.pc, m_id.pc);
    check("id_pc4", oID.pc4, m_id.pc4);
    check("id_instr", oID.instruction, m_id.instruction);
    check("id_valid", {31'b0, oID.valid}, {31'b0, m_id.valid});
  endtask

  // Called at a negedge: check, drive, advance model, move to next negedge.
  task automatic step(input bit stall, input bit flush, input bit br,
                      input logic [31:0] brpc, input bit ack);
    logic [31:0] data;
    check_outputs();
    data = ack ? mem_word(m_addr) : 32'hDEAD_BEEF;
    iStall = stall; iFlush = flush; iBrTrue = br; iBrPc = brpc;
    iImemAck = ack; iImemData = data;
    model_step(stall, flush, br, brpc, ack, data);
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic do_reset(input int ncyc);
    nRst = 1'b0;
    #1;
    check("rst_req", {31'b0, oImemReq}, 32'h0);
    check("rst_valid", {31'b0, oID.valid}, 32'h0);
    check("rst_instr", oID.instruction, NOP);
    check("rst_pc", oID.pc, 32'h0);
    iStall = 0; iFlush = 0; iBrTrue = 0; iBrPc = '0; iImemAck = 1'b1; iImemData = '0;
    model_reset();
    repeat (ncyc) @(posedge iClk);
    @(negedge iClk);
    check("rst_hold_req", {31'b0, oImemReq}, 32'h0);
    iImemAck = 1'b0;
    nRst = 1'b1;
  endtask

  initial begin
    @(negedge iClk);
    do_reset(3);

    // 1: same-cycle acks, ack in IDLE ignored
    step(0, 0, 0, 0, 1);
    check("s1_addr0", oImemAddr, 32'h0);
    repeat (3) step(0, 0, 0, 0, 1);
    check("s1_pc", oID.pc, 32'h8);
    check("s1_valid", {31'b0, oID.valid}, 32'h1);

    // 2: stall in ack cycle for 0x10
    step(0, 0, 0, 0, 1);
    check("s2_addr", oImemAddr, 32'h10);
    step(1, 0, 0, 0, 1);
    check("s2_req_hold", {31'b0, oImemReq}, 32'h0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("s2_pc", oID.pc, 32'h10);
    check("s2_instr", oID.instruction, mem_word(32'h10));
    check("s2_next", oImemAddr, 32'h14);

    // 3: redirect while ack is delayed
    step(0, 0, 1, 32'h20, 1);
    step(0, 0, 1, 32'h100, 0);
    check("s3_keep", oImemAddr, 32'h20);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("s3_next", oImemAddr, 32'h100);
    check("s3_bubble", {31'b0, oID.valid}, 32'h0);

    // 4: redirect in ack cycle
    step(0, 0, 1, 32'h30, 1);
    step(0, 0, 1, 32'h200, 1);
    check("s4_bubble", {31'b0, oID.valid}, 32'h0);
    check("s4_next", oImemAddr, 32'h200);

    // 5: flush beats stall
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    check("s5_bubble", {31'b0, oID.valid}, 32'h0);
    check("s5_addr", oImemAddr, 32'h204);

    // 6: redirect from HOLD discards buffer
    step(0, 0, 1, 32'h40, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 32'h80, 0);
    check("s6_next", oImemAddr, 32'h80);
    step(0, 0, 0, 0, 1);
    check("s6_pc", oID.pc, 32'h80);

    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFF8, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("wrap_pc4", oID.pc4, 32'h0);
    check("wrap_addr", oImemAddr, 32'h0);

    // Random traffic with one reset in the middle of a request
    for (int i = 0; i < 3000; i++) begin
      bit          st, fl, br, ak;
      logic [31:0] tgt;
      if (i == 1500) begin
        do_reset(2);
      end
      st  = ($urandom_range(99) < 25);
      fl  = ($urandom_range(99) < 8);
      br  = ($urandom_range(99) < 10);
      tgt = ($urandom_range(4) == 0) ? (32'hFFFF_FFF0 + ({$urandom} & 32'hC))
                                     : ({$urandom} & 32'h0000_FFFC);
      ak  = m_req() && ($urandom_range(99) < 60);
      step(st, fl, br, tgt, ak);
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
